// File: rtl/sram_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_if
// One SRAM-like request/response port. The requester drives the request
// fields and consumes the handshakes and read data; the responder does the
// reverse.
//   req      request valid, held until addr_ok
//   wr       write flag
//   size     0=byte, 1=half, 2=word
//   addr     byte address
//   wdata    write data
//   rdata    read data, qualified by data_ok
//   addr_ok  address handshake accepted this cycle
//   data_ok  data phase complete this cycle
// Modports:
//   master : requester side (drives req/wr/size/addr/wdata)
//   slave  : responder side (drives rdata/addr_ok/data_ok)
// ---------------------------------------------------------------------------
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
// Shares one SRAM-like downstream port between the instruction and data
// requesters. Data has priority unless instruction has lost STARVE_LIMIT
// consecutive accepts. A grant is held until its address handshake completes.
// The owner of every accepted transaction is recorded in an order FIFO so
// returning data_ok pulses are routed back to the right requester.
// Ports:
//   clk       clock, all state on rising edge
//   reset     synchronous, active-high
//   inst_bus  instruction requester (slave side of the port)
//   data_bus  data requester (slave side of the port)
//   mem_bus   shared downstream port (master side)
//   pend_cnt  number of outstanding (accepted, not returned) transactions
//   err       sticky: data_ok arrived with nothing outstanding
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_req_arbiter_if.slave      inst_bus,
  sram_req_arbiter_if.slave      data_bus,
  sram_req_arbiter_if.master     mem_bus,
  output logic [$clog2(DEPTH):0] pend_cnt,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  logic           lock_v_q, lock_v_d;
  logic           lock_sel_q, lock_sel_d;
  logic [DEPTH-1:0] order_q, order_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  pend_q, pend_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           err_q, err_d;

  logic sel;
  logic sel_req;
  logic full;
  logic accept;
  logic ret;
  logic head;

  // Grant selection from registered state; a held lock overrides priority.
  always_comb begin
    if (lock_v_q) begin
      sel = lock_sel_q;
    end else if ((starve_q == SW'(STARVE_LIMIT)) && inst_bus.req) begin
      sel = SEL_INST;
    end else if (data_bus.req) begin
      sel = SEL_DATA;
    end else begin
      sel = SEL_INST;
    end
  end

  // Request mux towards the downstream port.
  always_comb begin
    if (sel == SEL_DATA) begin
      sel_req       = data_bus.req;
      mem_bus.wr    = data_bus.wr;
      mem_bus.size  = data_bus.size;
      mem_bus.addr  = data_bus.addr;
      mem_bus.wdata = data_bus.wdata;
    end else begin
      sel_req       = inst_bus.req;
      mem_bus.wr    = inst_bus.wr;
      mem_bus.size  = inst_bus.size;
      mem_bus.addr  = inst_bus.addr;
      mem_bus.wdata = inst_bus.wdata;
    end
  end

  // A full FIFO blocks the request; a same-cycle pop does not unblock it.
  assign full        = (pend_q == CW'(DEPTH));
  assign mem_bus.req = sel_req & ~full & ~reset;
  assign accept      = mem_bus.req & mem_bus.addr_ok;
  assign ret         = mem_bus.data_ok & (pend_q != CW'(0));
  assign head        = order_q[rd_ptr_q];

  assign inst_bus.addr_ok = accept & (sel == SEL_INST);
  assign data_bus.addr_ok = accept & (sel == SEL_DATA);
  assign inst_bus.data_ok = ret & (head == SEL_INST);
  assign data_bus.data_ok = ret & (head == SEL_DATA);
  assign inst_bus.rdata   = mem_bus.rdata;
  assign data_bus.rdata   = mem_bus.rdata;

  assign pend_cnt = pend_q;
  assign err      = err_q;

  // Next-state for lock, order FIFO, starvation counter and error flag.
  always_comb begin
    lock_v_d   = lock_v_q;
    lock_sel_d = lock_sel_q;
    order_d    = order_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_d     = pend_q;
    starve_d   = starve_q;
    err_d      = err_q;

    // Lock on a stalled address phase; release on accept or if the owner
    // withdraws its request (nothing is issued in that case).
    if (mem_bus.req && !mem_bus.addr_ok) begin
      lock_v_d   = 1'b1;
      lock_sel_d = sel;
    end else if (accept) begin
      lock_v_d = 1'b0;
    end else if (lock_v_q && !sel_req) begin
      lock_v_d = 1'b0;
    end else begin
      lock_v_d = lock_v_q;
    end

    if (accept) begin
      order_d[wr_ptr_q] = sel;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (ret) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({accept, ret})
      2'b10:   pend_d = pend_q + CW'(1);
      2'b01:   pend_d = pend_q - CW'(1);
      default: pend_d = pend_q;
    endcase

    // Count accepts inst lost while asking; saturate at the limit.
    if (!inst_bus.req) begin
      starve_d = SW'(0);
    end else if (accept && (sel == SEL_INST)) begin
      starve_d = SW'(0);
    end else if (accept && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end

    if (mem_bus.data_ok && (pend_q == CW'(0))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_v_q   <= 1'b0;
      lock_sel_q <= 1'b0;
      order_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= '0;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_v_q   <= lock_v_d;
      lock_sel_q <= lock_sel_d;
      order_q    <= order_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
// Drives both requesters and plays the downstream bridge. Every cycle the
// stimulus side computes the expected outputs from a queue-based model of
// the arbitration rules and pushes them to a scoreboard; a monitor pops and
// compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [$clog2(DEPTH):0] pend_cnt;
  logic                   err;

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if mem_if ();

  sram_req_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .inst_bus (inst_if),
    .data_bus (data_if),
    .mem_bus  (mem_if),
    .pend_cnt (pend_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] rdata;
    logic        i_aok;
    logic        d_aok;
    logic        i_dok;
    logic        d_dok;
    int          pend;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   owner_q[$];   // owners of outstanding transactions, oldest first
  int   holder = -1;  // requester holding the port, -1 when free
  int   losses = 0;   // consecutive accepts inst lost while requesting
  bit   err_m  = 1'b0;
  bit   i_acc, d_acc;
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endfunction

  task automatic set_inst(bit rq, bit w, bit [1:0] sz, bit [31:0] a, bit [31:0] wd);
    inst_if.req = rq; inst_if.wr = w; inst_if.size = sz;
    inst_if.addr = a; inst_if.wdata = wd;
  endtask

  task automatic set_data(bit rq, bit w, bit [1:0] sz, bit [31:0] a, bit [31:0] wd);
    data_if.req = rq; data_if.wr = w; data_if.size = sz;
    data_if.addr = a; data_if.wdata = wd;
  endtask

  task automatic set_mem(bit aok, bit dok, bit [31:0] rd);
    mem_if.addr_ok = aok; mem_if.data_ok = dok; mem_if.rdata = rd;
  endtask

  // Predict this cycle's outputs from the current inputs, then advance the
  // model and the clock.
  task automatic step();
    exp_t e;
    int   g;
    bit   greq, mreq, acc, ret;
    if (holder >= 0) g = holder;
    else if (losses >= STARVE_LIMIT && inst_if.req) g = 0;
    else if (data_if.req) g = 1;
    else g = 0;
    greq = (g == 1) ? data_if.req : inst_if.req;
    mreq = greq && (owner_q.size() < DEPTH) && !reset;
    acc  = mreq && mem_if.addr_ok;
    ret  = mem_if.data_ok && (owner_q.size() > 0);
    e.m_req   = mreq;
    e.m_wr    = (g == 1) ? data_if.wr    : inst_if.wr;
    e.m_size  = (g == 1) ? data_if.size  : inst_if.size;
    e.m_addr  = (g == 1) ? data_if.addr  : inst_if.addr;
    e.m_wdata = (g == 1) ? data_if.wdata : inst_if.wdata;
    e.rdata   = mem_if.rdata;
    e.i_aok   = acc && (g == 0);
    e.d_aok   = acc && (g == 1);
    e.i_dok   = 1'b0;
    e.d_dok   = 1'b0;
    if (ret) begin
      e.i_dok = (owner_q[0] == 0);
      e.d_dok = (owner_q[0] == 1);
    end
    e.pend = owner_q.size();
    e.err  = err_m;
    exp_q.push_back(e);
    i_acc = e.i_aok;
    d_acc = e.d_aok;

    if (mem_if.data_ok && owner_q.size() == 0) err_m = 1'b1;
    if (ret) void'(owner_q.pop_front());
    if (acc) owner_q.push_back(g);
    if (mreq && !mem_if.addr_ok) holder = g;
    else if (acc) holder = -1;
    else if (holder >= 0 && !greq) holder = -1;
    if (!inst_if.req) losses = 0;
    else if (acc && g == 0) losses = 0;
    else if (acc && g == 1 && losses < STARVE_LIMIT) losses++;
    if (reset) begin
      owner_q.delete();
      holder = -1;
      losses = 0;
      err_m  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && owner_q.size() > 0; k++) begin
      set_mem(1'b0, 1'b1, $urandom);
      step();
    end
    set_mem(1'b0, 1'b0, 32'h0);
    step();
  endtask

  // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m_req", 32'(mem_if.req), 32'(e.m_req));
        if (e.m_req) begin
          chk("m_addr",  mem_if.addr,        e.m_addr);
          chk("m_wdata", mem_if.wdata,       e.m_wdata);
          chk("m_wr",    32'(mem_if.wr),     32'(e.m_wr));
          chk("m_size",  32'(mem_if.size),   32'(e.m_size));
        end
        chk("inst_addr_ok", 32'(inst_if.addr_ok), 32'(e.i_aok));
        chk("data_addr_ok", 32'(data_if.addr_ok), 32'(e.d_aok));
        chk("inst_data_ok", 32'(inst_if.data_ok), 32'(e.i_dok));
        chk("data_data_ok", 32'(data_if.data_ok), 32'(e.d_dok));
        if (e.i_dok) chk("inst_rdata", inst_if.rdata, e.rdata);
        if (e.d_dok) chk("data_rdata", data_if.rdata, e.rdata);
        chk("pend_cnt", 32'(pend_cnt), 32'(e.pend));
        chk("err",      32'(err),      32'(e.err));
      end
    end
  end

  initial begin
    bit ia, da, rq;
    ia = 1'b0;
    da = 1'b0;
    reset = 1'b1;
    set_inst(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_data(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_mem(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    step();

    // Single inst read: two stall cycles, accept, data three cycles later.
    set_inst(1'b1, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    step();
    step();
    set_mem(1'b1, 1'b0, 32'h0);
    step();
    set_inst(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    set_mem(1'b0, 1'b0, 32'h0);
    step();
    step();
    set_mem(1'b0, 1'b1, 32'h3C08_0001);
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    step();

    // Simultaneous requests: data first, then inst; returns in that order.
    set_inst(1'b1, 1'b0, 2'd2, 32'hBFC0_0004, 32'h0);
    set_data(1'b1, 1'b1, 2'd2, 32'h8000_1000, 32'h1234_5678);
    set_mem(1'b1, 1'b0, 32'h0);
    step();
    set_data(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    step();
    set_inst(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_mem(1'b0, 1'b1, 32'hAAAA_0001);
    step();
    set_mem(1'b0, 1'b1, 32'hAAAA_0002);
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    step();

    // Lock: inst stalls four cycles, data arrives meanwhile and must wait.
    set_inst(1'b1, 1'b0, 2'd2, 32'hBFC0_0010, 32'h0);
    step();
    set_data(1'b1, 1'b0, 2'd2, 32'h8000_2000, 32'h0);
    step();
    step();
    step();
    set_mem(1'b1, 1'b0, 32'h0);
    step();
    set_inst(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    step();
    set_data(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    drain();

    // Full: four data reads outstanding, then a pop frees a slot next cycle.
    set_mem(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      set_data(1'b1, 1'b0, 2'd2, 32'h8000_3000 + 32'(4 * k), 32'h0);
      step();
    end
    set_inst(1'b1, 1'b0, 2'd2, 32'hBFC0_0020, 32'h0);
    step();
    set_mem(1'b1, 1'b1, 32'hBEEF_0001);
    step();
    set_mem(1'b1, 1'b0, 32'h0);
    step();
    set_inst(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_data(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    drain();

    // Starvation: both requesting continuously with addr_ok held high.
    set_inst(1'b1, 1'b0, 2'd2, 32'hBFC0_0100, 32'h0);
    set_data(1'b1, 1'b0, 2'd2, 32'h8000_4000, 32'h0);
    for (int k = 0; k < 14; k++) begin
      set_mem(1'b1, owner_q.size() > 0, $urandom);
      step();
    end
    set_inst(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_data(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    drain();

    // Spurious return: err sticks until reset.
    set_mem(1'b0, 1'b1, 32'h5555_5555);
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Randomized traffic including protocol drops and mid-flight resets.
    for (int c = 0; c < 3000; c++) begin
      if (!ia && $urandom_range(0, 99) < 40) begin
        ia = 1'b1;
        set_inst(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      end else if (ia && $urandom_range(0, 99) < 2) begin
        ia = 1'b0;
      end
      if (!da && $urandom_range(0, 99) < 40) begin
        da = 1'b1;
        set_data(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      end else if (da && $urandom_range(0, 99) < 2) begin
        da = 1'b0;
      end
      inst_if.req = ia;
      data_if.req = da;
      reset = ($urandom_range(0, 199) == 0);
      if (reset) rq = 1'b0;
      else if (owner_q.size() > 0) rq = ($urandom_range(0, 99) < 50);
      else rq = ($urandom_range(0, 99) < 1);
      set_mem(($urandom_range(0, 99) < 60), rq, $urandom);
      step();
      if (i_acc) ia = 1'b0;
      if (d_acc) da = 1'b0;
    end

    reset = 1'b0;
    set_inst(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_data(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_mem(1'b0, 1'b0, 32'h0);
    step();
    step();
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
